// File: rtl/uart_pkg.sv
// Shared constants, greeting ROM and FSM state types for the UART echo/greeting block.
package uart_pkg;

    localparam int CLKS_PER_BIT_200M_115200 = 1736;
    localparam int GREET_LEN                = 13;

    // "HELLO ALINX\r\n"
    localparam logic [7:0] GREET_ROM [GREET_LEN] = '{
        8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h41,
        8'h4C, 8'h49, 8'h4E, 8'h58, 8'h0D, 8'h0A
    };

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        CTL_WAIT,
        CTL_GREET,
        CTL_ECHO
    } ctl_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling FSM, one-cycle rx_valid per good byte.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_200M_115200
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       sync_q;
    logic             prev_q;
    logic             line;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;

    assign line     = sync_q[1];
    assign rx_data  = shift_q;
    assign rx_valid = valid_q;

    always_comb begin
        // NOTE: every value written here gets a default first, so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !line) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    if (line) begin
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                cnt_d = '0;
                if (line) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], uart_rx};
            prev_q  <= line;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/uart_echo_test.sv
// Bring-up UART: sends a periodic greeting and echoes each correctly framed received byte.
module uart_echo_test
    import uart_pkg::*;
#(
    parameter int CLK_FRE      = 200,
    parameter int BAUD_RATE    = 115200,
    parameter int GREET_PERIOD = 200_000_000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic uart_rx,
    output logic uart_tx
);

    localparam int                CLKS_PER_BIT = CLK_FRE * 1_000_000 / BAUD_RATE;
    localparam int                CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int                GP_W         = $clog2(GREET_PERIOD);
    localparam logic [CNT_W-1:0]  BIT_END      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [GP_W-1:0]   GREET_LAST   = GP_W'(GREET_PERIOD - 1);
    localparam logic [3:0]        GREET_END    = 4'(GREET_LEN);

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [7:0]       echo_data_q;
    logic             pending_q;
    logic             clear_pending;

    ctl_state_t       ctl_q, ctl_d;
    logic [GP_W-1:0]  greet_cnt_q, greet_cnt_d;
    logic [3:0]       greet_idx_q, greet_idx_d;

    logic             tx_start;
    logic [7:0]       tx_byte;
    logic             tx_active_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [3:0]       tx_idx_q;
    logic [7:0]       tx_data_q;
    logic             tx_done;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    // Last cycle of a stop bit; a new frame may load on this same edge, giving no idle gap.
    assign tx_done = tx_active_q && (tx_cnt_q == BIT_END) && (tx_idx_q == 4'd9);

    always_comb begin
        ctl_d         = ctl_q;
        greet_cnt_d   = greet_cnt_q;
        greet_idx_d   = greet_idx_q;
        tx_start      = 1'b0;
        tx_byte       = echo_data_q;
        clear_pending = 1'b0;
        case (ctl_q)
            CTL_WAIT: begin
                if (greet_cnt_q == GREET_LAST) begin
                    greet_cnt_d = '0;
                    greet_idx_d = '0;
                    ctl_d       = CTL_GREET;
                end else begin
                    greet_cnt_d = greet_cnt_q + 1'b1;
                    if (pending_q) ctl_d = CTL_ECHO;
                end
            end
            CTL_GREET: begin
                if (greet_idx_q == GREET_END) begin
                    if (tx_done) ctl_d = CTL_WAIT;
                end else if (!tx_active_q || tx_done) begin
                    tx_start    = 1'b1;
                    tx_byte     = GREET_ROM[greet_idx_q];
                    greet_idx_d = greet_idx_q + 1'b1;
                end
            end
            CTL_ECHO: begin
                if (!tx_active_q) begin
                    tx_start      = 1'b1;
                    clear_pending = 1'b1;
                end else if (tx_done) begin
                    ctl_d = CTL_WAIT;
                end
            end
            default: ctl_d = CTL_WAIT;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            ctl_q       <= CTL_WAIT;
            greet_cnt_q <= '0;
            greet_idx_q <= '0;
        end else begin
            ctl_q       <= ctl_d;
            greet_cnt_q <= greet_cnt_d;
            greet_idx_q <= greet_idx_d;
        end
    end

    // A newly received byte wins over a same-cycle clear: the older byte is already loading into TX.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            echo_data_q <= '0;
            pending_q   <= 1'b0;
        end else if (rx_valid) begin
            echo_data_q <= rx_data;
            pending_q   <= 1'b1;
        end else if (clear_pending) begin
            pending_q <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tx_active_q <= 1'b0;
            tx_cnt_q    <= '0;
            tx_idx_q    <= '0;
            tx_data_q   <= '0;
            uart_tx     <= 1'b1;
        end else if (tx_start) begin
            tx_active_q <= 1'b1;
            tx_cnt_q    <= '0;
            tx_idx_q    <= '0;
            tx_data_q   <= tx_byte;
            uart_tx     <= 1'b0;
        end else if (tx_active_q) begin
            if (tx_cnt_q == BIT_END) begin
                tx_cnt_q <= '0;
                if (tx_idx_q == 4'd9) begin
                    tx_active_q <= 1'b0;
                end else begin
                    tx_idx_q <= tx_idx_q + 1'b1;
                    uart_tx  <= (tx_idx_q == 4'd8) ? 1'b1 : tx_data_q[tx_idx_q[2:0]];
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_echo_test.sv
// Scoreboard bench for uart_echo_test: stimulus queues expected TX frames, a monitor decodes and compares them.
module tb_uart_echo_test;

    localparam int CLK_FRE      = 200;
    localparam int BAUD_RATE    = 10_000_000;
    localparam int CPB          = CLK_FRE * 1_000_000 / BAUD_RATE;
    localparam int GREET_PERIOD = 4000;
    localparam int FRAME        = 10 * CPB;

    localparam logic [7:0] GREET_EXP [13] = '{
        8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h41,
        8'h4C, 8'h49, 8'h4E, 8'h58, 8'h0D, 8'h0A
    };

    typedef struct {
        logic [7:0] data;
        int         gap;
        int         tol;
    } exp_t;

    exp_t exp_q[$];

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx;

    int errors     = 0;
    int checks     = 0;
    int cyc        = 0;
    int prev_start = 0;

    uart_echo_test #(
        .CLK_FRE      (CLK_FRE),
        .BAUD_RATE    (BAUD_RATE),
        .GREET_PERIOD (GREET_PERIOD)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input int gap, input int tol);
        exp_t e;
        e.data = d;
        e.gap  = gap;
        e.tol  = tol;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rx = f[k];
            repeat (CPB) @(negedge sys_clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic wait_level(input string name, input int level, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() > level && n < max_cycles) begin
            @(negedge sys_clk);
            n++;
        end
        check_range(name, exp_q.size(), 0, level);
    endtask

    // Decode every frame on uart_tx at mid-bit and compare against the head of the queue.
    initial begin : monitor
        logic [9:0] bits;
        int         t;
        exp_t       e;
        forever begin
            @(negedge sys_clk);
            if (!rst && uart_tx === 1'b0) begin
                t = cyc;
                for (int k = 0; k < 10; k++) begin
                    repeat (k == 0 ? CPB / 2 : CPB) @(negedge sys_clk);
                    bits[k] = uart_tx;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got frame %03h, expected no frame", bits);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("frame_%02h", e.data), 32'(bits), 32'({1'b1, e.data, 1'b0}));
                    if (e.gap >= 0)
                        check_range($sformatf("start_gap_%02h", e.data), t - prev_start,
                                    e.gap - e.tol, e.gap + e.tol);
                end
                prev_start = t;
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: got timeout, expected run to complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic reset_ok;
        reset_ok = 1'b1;
        rst      = 1'b1;
        uart_rx  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk);
            if (uart_tx !== 1'b1) reset_ok = 1'b0;
        end
        check("reset_uart_tx_high", 32'(reset_ok), 32'd1);

        // Two consecutive greetings with idle RX: the second starts a full period after the first ends.
        for (int i = 0; i < 13; i++)
            push_exp(GREET_EXP[i], (i == 0) ? GREET_PERIOD + 1 : FRAME, (i == 0) ? 1 : 0);
        for (int i = 0; i < 13; i++)
            push_exp(GREET_EXP[i], (i == 0) ? FRAME + GREET_PERIOD + 1 : FRAME, (i == 0) ? 1 : 0);
        prev_start = cyc;
        rst = 1'b0;

        // Byte received mid-greeting is echoed right after the closing 0x0A.
        wait_level("greeting2_in_progress", 10, 20000);
        push_exp(8'h31, FRAME + 2, 1);
        send_byte(8'h31, 1'b1);
        wait_level("drain_greeting_echo", 0, 5000);

        push_exp(8'hA3, -1, 0);
        send_byte(8'hA3, 1'b1);
        wait_level("drain_echo_a3", 0, 1000);

        // Framing error: nothing echoed, following good byte still echoed.
        send_byte(8'hA3, 1'b0);
        repeat (2 * CPB) @(negedge sys_clk);
        push_exp(8'h55, -1, 0);
        send_byte(8'h55, 1'b1);
        wait_level("drain_echo_55", 0, 1000);

        // Short low pulse is a false start; the next byte is received cleanly.
        uart_rx = 1'b0;
        repeat (CPB / 4) @(negedge sys_clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge sys_clk);
        push_exp(8'h0F, -1, 0);
        send_byte(8'h0F, 1'b1);
        wait_level("drain_echo_0f", 0, 1000);

        repeat (3 * FRAME) @(negedge sys_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
